// File: rtl/sram_param.sv
// sram_param: single-port SRAM that clears itself to INIT_VAL after reset; read data is registered (latency 1).
// No backpressure: accesses presented while busy is high are dropped, otherwise one access is accepted per cycle.
module sram_param #(
   parameter int                DATA_W     = 4,
   parameter int                ADDR_W     = 4,
   parameter bit                INVERT_OUT = 1'b1,
   parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              we_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdat;
   logic              rd_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // The clear counter saturates at DEPTH-1 so it never wraps back into the array.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_cnt <= '0;
      end else if (state == CLEAR && !(&clr_cnt)) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = addr;
      mem_wdat  = din;
      rd_en     = 1'b0;
      case (state)
         CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdat  = INIT_VAL;
            if (&clr_cnt) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (!cs_n) begin
               if (!we_n) begin
                  mem_we = 1'b1;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Array has no reset of its own; its contents are defined only by the clear walk.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_waddr] <= mem_wdat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (rd_en) begin
         dout       <= INVERT_OUT ? ~mem[addr] : mem[addr];
         dout_valid <= 1'b1;
      end else begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_param.sv
// Bench for sram_param: default instance against a behavioural model, plus an 8x64 true-data instance.
module tb_sram_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, cs_n, we_n;
   logic [3:0] addr, din, dout;
   logic       dout_valid, busy;

   logic       rst8_n, cs8_n, we8_n;
   logic [5:0] addr8;
   logic [7:0] din8, dout8;
   logic       dout8_valid, busy8;

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model state for the default instance
   logic [3:0] mem_m [16];
   int         clr_left;
   int         clr_pos;
   logic [3:0] dout_m;
   logic       valid_m;

   sram_param dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .we_n       (we_n),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   sram_param #(
      .DATA_W     (8),
      .ADDR_W     (6),
      .INVERT_OUT (1'b0),
      .INIT_VAL   (8'h11)
   ) dut8 (
      .clk        (clk),
      .rst_n      (rst8_n),
      .cs_n       (cs8_n),
      .we_n       (we8_n),
      .addr       (addr8),
      .din        (din8),
      .dout       (dout8),
      .dout_valid (dout8_valid),
      .busy       (busy8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the default instance: update the model, step, compare all outputs.
   task automatic cyc(input string ph, input logic r, input logic c, input logic w,
                      input logic [3:0] a, input logic [3:0] d);
      rst_n = r; cs_n = c; we_n = w; addr = a; din = d;
      if (!r) begin
         clr_left = 16; clr_pos = 0; dout_m = 4'h0; valid_m = 1'b0;
      end else if (clr_left > 0) begin
         mem_m[clr_pos] = 4'h0; clr_pos++; clr_left--;
         dout_m = 4'h0; valid_m = 1'b0;
      end else if (!c && !w) begin
         mem_m[a] = d; dout_m = 4'h0; valid_m = 1'b0;
      end else if (!c) begin
         dout_m = ~mem_m[a]; valid_m = 1'b1;
      end else begin
         dout_m = 4'h0; valid_m = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({ph, ".busy"},  32'(busy),       32'(clr_left > 0));
      chk({ph, ".dout"},  32'(dout),       32'(dout_m));
      chk({ph, ".valid"}, 32'(dout_valid), 32'(valid_m));
   endtask

   task automatic cyc8(input logic r, input logic c, input logic w,
                       input logic [5:0] a, input logic [7:0] d);
      rst8_n = r; cs8_n = c; we8_n = w; addr8 = a; din8 = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst8_n = 1'b0; cs8_n = 1'b1; we8_n = 1'b1; addr8 = '0; din8 = '0;
      clr_left = 0; clr_pos = 0; dout_m = '0; valid_m = 1'b0;

      cyc("rst", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      cyc("rst", 1'b0, 1'b0, 1'b0, 4'h3, 4'h9);

      // clear walk with a noisy bus; a write to addr 5 on the 3rd cycle must be dropped
      for (int i = 0; i < 16; i++) begin
         if (i == 2) cyc("clr", 1'b1, 1'b0, 1'b0, 4'h5, 4'h6);
         else cyc("clr", 1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      end
      chk("clr_done", 32'(busy), 32'(0));

      for (int i = 0; i < 16; i++) begin
         cyc("rd_all", 1'b1, 1'b0, 1'b1, 4'(i), 4'h0);
         chk("rd_all_f", 32'(dout), 32'h0000000F);
      end

      cyc("wr3", 1'b1, 1'b0, 1'b0, 4'h3, 4'hA);
      cyc("rd3", 1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
      chk("rd3_5", 32'(dout), 32'h5);
      cyc("desel", 1'b1, 1'b1, 1'b1, 4'h3, 4'h0);
      chk("pulse_end", 32'(dout_valid), 32'(0));

      cyc("nocs_wr", 1'b1, 1'b1, 1'b0, 4'h3, 4'h0);
      cyc("rd3b", 1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
      chk("nocs_kept", 32'(dout), 32'h5);

      // reset again and interrupt the clear when the counter reaches 7
      cyc("rst2", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 7; i++) cyc("clr2", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
      cyc("rst3", 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 16; i++) cyc("clr3", 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
      cyc("rd3c", 1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
      chk("rd3_cleared", 32'(dout), 32'hF);

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         cyc("rand", 1'(($urandom % 150) != 0), 1'(($urandom % 4) == 0),
             1'($urandom), 4'($urandom), 4'($urandom));
      end

      // 8x64 true-data instance
      cs_n = 1'b1;
      cyc8(1'b0, 1'b1, 1'b1, 6'd0, 8'h00);
      chk("w8.rst_busy",  32'(busy8),       32'(1));
      chk("w8.rst_dout",  32'(dout8),       32'(0));
      chk("w8.rst_valid", 32'(dout8_valid), 32'(0));
      for (int i = 0; i < 64; i++) begin
         cyc8(1'b1, 1'b0, 1'b0, 6'd63, 8'hFF);
         chk("w8.busy", 32'(busy8), 32'(i < 63));
      end
      cyc8(1'b1, 1'b0, 1'b0, 6'd63, 8'h3C);
      chk("w8.wr_valid", 32'(dout8_valid), 32'(0));
      cyc8(1'b1, 1'b0, 1'b1, 6'd63, 8'h00);
      chk("w8.rd63",   32'(dout8),       32'h3C);
      chk("w8.v63",    32'(dout8_valid), 32'(1));
      cyc8(1'b1, 1'b0, 1'b1, 6'd0, 8'h00);
      chk("w8.rd0",    32'(dout8),       32'h11);
      chk("w8.v0",     32'(dout8_valid), 32'(1));
      cyc8(1'b1, 1'b1, 1'b1, 6'd0, 8'h00);
      chk("w8.idle_d", 32'(dout8),       32'(0));
      chk("w8.idle_v", 32'(dout8_valid), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
